seg7_scan_controller: RTL and testbench

//  Drives a multiplexed 4-digit common-anode 7-segment display from a binary value, such as a servo position.
//  The value is accepted over a valid/ready handshake and converted to BCD by a sequential shift-add-3 engine.
//  The BCD digits are latched atomically into a display register.
//  One shared Decoder_7SEG instance is time-multiplexed across the digits by a prescaled scan counter.

---
 rtl/seg7_pkg.sv | 11 +
 rtl/seg7_scan_controller_if.sv | 10 +
 rtl/Decoder_7SEG.sv | 21 ++
 rtl/bin2bcd_seq.sv | 45 ++++
 rtl/seg7_scan_controller.sv | 73 +++++++
 tb/tb_seg7_scan_controller.sv | 135 +++++++++++++
 6 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, FSM encoding and helpers for the 7-segment scan controller
// Contents: SEG_BLANK (all segments off, active-low), state_t (IDLE/CONVERT/COMMIT), max_dec(digits)
package seg7_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
   function automatic int unsigned max_dec(input int unsigned digits);
      int unsigned r = 1;
      for (int unsigned i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction
endpackage

// File: rtl/seg7_scan_controller_if.sv
// seg7_scan_controller_if: value handshake between a producer and the scan controller
// Ports: value_in/value_valid (producer -> controller), value_ready/busy (controller -> producer)
interface seg7_scan_controller_if #(parameter int BIN_W = 14);
   logic [BIN_W-1:0] value_in;
   logic value_valid;
   logic value_ready;
   logic busy;
   modport master (output value_in, value_valid, input value_ready, busy);
   modport slave (input value_in, value_valid, output value_ready, busy);
endinterface

// File: rtl/Decoder_7SEG.sv
// Decoder_7SEG: BCD digit to active-low segments {g..a}; out-of-range codes show "0"
// Ports: digit (4-bit BCD in), seg (7-bit active-low segments out)
module Decoder_7SEG (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   always_comb begin
      case (digit)
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1000000;
      endcase
   end
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD engine, one iteration per cycle
// Ports: clk, rst_n (sync, active-low), start loads bin_in, bcd_out holds the digits,
//        done is high on the cycle whose edge performs the final iteration
module bin2bcd_seq #(
   parameter int BIN_W = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [BIN_W-1:0]        bin_in,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    done
);
   localparam int DW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(BIN_W + 1);
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [DW-1:0] bcd_q, bcd_d, adj;
   logic [CW-1:0] cnt_q, cnt_d;
   logic run_q, run_d;
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      done = run_q && cnt_q == CW'(BIN_W - 1);
      bin_d = start ? bin_in : run_q ? bin_q << 1 : bin_q;
      bcd_d = start ? '0 : run_q ? (adj << 1) | DW'(bin_q[BIN_W-1]) : bcd_q;
      cnt_d = start ? '0 : run_q ? cnt_q + CW'(1) : cnt_q;
      run_d = start || (run_q && !done);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end
   assign bcd_out = bcd_q;
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: accepts a binary value, converts it to BCD and scans it onto a multiplexed display
// Ports: clk, rst_n (sync, active-low), bus (value_in/value_valid in, value_ready/busy out),
//        seg_out (active-low {g..a}, registered), digit_en (active-low one-hot, registered)
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W = 14,
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   seg7_scan_controller_if.slave     bus,
   output logic [6:0]                seg_out,
   output logic [NUM_DIGITS-1:0]     digit_en
);
   localparam int DW = 4 * NUM_DIGITS;
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [BIN_W-1:0] MAX_V = BIN_W'(max_dec(NUM_DIGITS));
   state_t state_q, state_d;
   logic [DW-1:0] disp_q, disp_d, bcd;
   logic [PW-1:0] pre_q, pre_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [6:0] seg_q, seg_d, dec_seg;
   logic [NUM_DIGITS-1:0] en_q, en_d, blank;
   logic [BIN_W-1:0] bin_sat;
   logic start, done, tc, zero;
   bin2bcd_seq #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_sat), .bcd_out(bcd), .done(done)
   );
   Decoder_7SEG u_dec (.digit(disp_q[4*idx_q +: 4]), .seg(dec_seg));
   always_comb begin
      bin_sat = bus.value_in > MAX_V ? MAX_V : bus.value_in;
      start = state_q == IDLE && bus.value_valid;
      state_d = start ? CONVERT : state_q == CONVERT && done ? COMMIT : state_q == COMMIT ? IDLE : state_q;
      disp_d = state_q == COMMIT ? bcd : disp_q;
   end
   always_comb begin
      tc = pre_q == PW'(SCAN_DIV - 1);
      pre_d = tc ? '0 : pre_q + PW'(1);
      idx_d = !tc ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
      zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero = zero && disp_q[4*i +: 4] == 4'd0;
         blank[i] = BLANK_LEADING != 0 && i > 0 && zero;
      end
      en_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = blank[idx_q] ? SEG_BLANK : dec_seg;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         disp_q <= '0;
         pre_q <= '0;
         idx_q <= '0;
         seg_q <= SEG_BLANK;
         en_q <= '1;
      end else begin
         state_q <= state_d;
         disp_q <= disp_d;
         pre_q <= pre_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         en_q <= en_d;
      end
   end
   assign bus.value_ready = state_q == IDLE;
   assign bus.busy = state_q != IDLE;
   assign seg_out = seg_q;
   assign digit_en = en_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed and random stimulus against a decimal-arithmetic display model
module tb_seg7_scan_controller;
   localparam int ND = 4;
   localparam int BW = 14;
   localparam int SD = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] seg0, seg1;
   logic [ND-1:0] en0, en1;
   int checks = 0;
   int errors = 0;
   int k = 0;
   int cd = 0;
   int disp_m = 0;
   int pend = 0;
   logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   seg7_scan_controller_if #(.BIN_W(BW)) bus0 ();
   seg7_scan_controller_if #(.BIN_W(BW)) bus1 ();
   seg7_scan_controller #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LEADING(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .seg_out(seg0), .digit_en(en0)
   );
   seg7_scan_controller #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LEADING(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .seg_out(seg1), .digit_en(en1)
   );
   always #5 clk = ~clk;
   function automatic int pow10(int n);
      int r = 1;
      repeat (n) r = r * 10;
      return r;
   endfunction
   function automatic logic [6:0] exp_seg(int val, int i, bit bl);
      if (bl && i > 0 && val < pow10(i)) return 7'h7F;
      return tbl[(val / pow10(i)) % 10];
   endfunction
   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, expv, k);
      end
   endtask
   task automatic drive(int v, bit vld);
      bus0.value_in = BW'(v);
      bus0.value_valid = vld;
      bus1.value_in = BW'(v);
      bus1.value_valid = vld;
   endtask
   task automatic tick();
      int prev = disp_m;
      int vin = int'(bus0.value_in);
      bit vld = bus0.value_valid;
      int idx;
      logic [ND-1:0] e;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         k = 0;
         cd = 0;
         disp_m = 0;
      end else begin
         k++;
         if (cd > 0) begin
            cd--;
            if (cd == 0) disp_m = pend;
         end else if (vld) begin
            cd = BW + 1;
            pend = vin > 9999 ? 9999 : vin;
         end
      end
      check("value_ready", bus0.value_ready, cd == 0);
      check("busy", bus0.busy, cd != 0);
      check("value_ready_nb", bus1.value_ready, cd == 0);
      if (k == 0) begin
         check("seg_rst", seg0, 7'h7F);
         check("en_rst", en0, 4'hF);
         check("seg_rst_nb", seg1, 7'h7F);
         check("en_rst_nb", en1, 4'hF);
      end else begin
         idx = (k - 1) / SD % ND;
         e = ~(ND'(1) << idx);
         check("digit_en", en0, e);
         check("seg_out", seg0, exp_seg(prev, idx, 1'b1));
         check("digit_en_nb", en1, e);
         check("seg_out_nb", seg1, exp_seg(prev, idx, 1'b0));
      end
   endtask
   task automatic send(int v);
      drive(v, 1'b1);
      tick();
      drive(0, 1'b0);
      repeat (BW + 2 + 2 * SD * ND) tick();
   endtask
   initial begin
      drive(0, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      send(1234);
      send(16383);
      send(7);
      drive(500, 1'b1);
      tick();
      drive(42, 1'b1);
      repeat (BW + 2) tick();
      drive(0, 1'b0);
      repeat (BW + 2 + 2 * SD * ND) tick();
      drive(8888, 1'b1);
      tick();
      drive(0, 1'b0);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (24) tick();
      repeat (40) begin
         repeat ($urandom_range(0, 20)) tick();
         drive(int'($urandom_range(0, 16383)), 1'b1);
         repeat ($urandom_range(1, 3)) begin
            tick();
            if ($urandom_range(0, 1) == 1) drive(int'($urandom_range(0, 16383)), 1'b1);
         end
         drive(0, 1'b0);
         if ($urandom_range(0, 15) == 0) begin
            repeat ($urandom_range(0, 10)) tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         repeat ($urandom_range(0, 40)) tick();
      end
      repeat (BW + 2 + 2 * SD * ND) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
